stopwatch_display: RTL

Four-digit multiplexed seven-segment driver that sits directly downstream of the stopwatch core. It consumes the core's `minutes`, `seconds` and `status` outputs and shows MM.SS on a common-anode display, scanning one digit at a time. It takes a tear-free snapshot of the time once per scan frame and blinks the display while the stopwatch is paused.

---
 rtl/stopwatch_pkg.sv | 15 +
 rtl/seg7_decoder.sv | 27 ++
 rtl/stopwatch_display.sv | 134 +++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared encodings for the stopwatch core and its display driver.
// Status codes, segment constants and digit-index width live here so both ends agree.
package stopwatch_pkg;

  localparam int DIGIT_W = 2;

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_RUNNING = 2'b01;
  localparam logic [1:0] ST_PAUSED  = 2'b10;

  // Active-low segment patterns, ordered {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

endpackage

// File: rtl/seg7_decoder.sv
// BCD digit to active-low seven-segment pattern {g,f,e,d,c,b,a}.
// Non-decimal codes 10..15 produce a dark digit.
module seg7_decoder
  import stopwatch_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_BLANK;
    case (bcd)
      4'd0: seg_n = 7'b1000000;
      4'd1: seg_n = 7'b1111001;
      4'd2: seg_n = 7'b0100100;
      4'd3: seg_n = 7'b0110000;
      4'd4: seg_n = 7'b0011001;
      4'd5: seg_n = 7'b0010010;
      4'd6: seg_n = 7'b0000010;
      4'd7: seg_n = 7'b1111000;
      4'd8: seg_n = 7'b0000000;
      4'd9: seg_n = 7'b0010000;
      default: seg_n = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/stopwatch_display.sv
// Four-digit multiplexed MM.SS driver for a common-anode display.
// Time and status are snapshotted once per scan frame; the display blinks while paused.
module stopwatch_display
  import stopwatch_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] minutes,
  input  logic [5:0] seconds,
  input  logic [1:0] status,
  output logic [3:0] an_n,
  output logic [6:0] seg_n,
  output logic       dp_n
);

  localparam int SCAN_W  = $clog2(SCAN_DIV);
  localparam int FRAME_W = $clog2(BLINK_FRAMES + 1);
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);
  localparam logic [DIGIT_W-1:0] DIGIT_LAST = '1;

  // Binary 0..127 split into {tens, ones}; tens is only meaningful below 100.
  function automatic logic [7:0] bcd_split(input logic [6:0] v);
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

  logic [SCAN_W-1:0]  scan_cnt;
  logic [DIGIT_W-1:0] digit_idx;
  logic [FRAME_W-1:0] frame_cnt;
  logic               phase_on;

  logic [6:0] snap_min_p0;
  logic [5:0] snap_sec_p0;
  logic [1:0] snap_st_p0;

  logic       digit_wrap;
  logic       frame_wrap;
  logic [1:0] next_st;
  logic [7:0] sec_bcd;
  logic [7:0] min_bcd;
  logic       min_ovf;
  logic [3:0] digit_bcd;
  logic [6:0] glyph;
  logic [6:0] seg_sel;
  logic [3:0] an_sel;
  logic       dp_sel;
  logic       blank;

  assign digit_wrap = (scan_cnt == SCAN_LAST);
  assign frame_wrap = digit_wrap && (digit_idx == DIGIT_LAST);
  assign next_st    = (status == 2'b11) ? ST_IDLE : status;

  // Stage p0 -> display: decode the frozen snapshot for the selected digit
  assign sec_bcd = bcd_split({1'b0, snap_sec_p0});
  assign min_bcd = bcd_split(snap_min_p0);
  assign min_ovf = (snap_min_p0 > 7'd99);
  assign blank   = (snap_st_p0 == ST_PAUSED) && !phase_on;

  always_comb begin
    digit_bcd = 4'd0;
    case (digit_idx)
      2'd0: digit_bcd = sec_bcd[3:0];
      2'd1: digit_bcd = sec_bcd[7:4];
      2'd2: digit_bcd = min_bcd[3:0];
      2'd3: digit_bcd = min_bcd[7:4];
      default: digit_bcd = 4'd0;
    endcase
  end

  seg7_decoder u_dec (
    .bcd   (digit_bcd),
    .seg_n (glyph)
  );

  always_comb begin
    seg_sel = glyph;
    if (digit_idx[1] && min_ovf) begin
      seg_sel = SEG_DASH;
    end else if ((digit_idx == 2'd3) && (min_bcd[7:4] == 4'd0)) begin
      seg_sel = SEG_BLANK;
    end
  end

  assign an_sel = blank ? 4'b1111 : ~(4'b0001 << digit_idx);
  assign dp_sel = blank || (digit_idx != 2'd2);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_cnt    <= '0;
      digit_idx   <= '0;
      frame_cnt   <= '0;
      phase_on    <= 1'b1;
      snap_min_p0 <= '0;
      snap_sec_p0 <= '0;
      snap_st_p0  <= ST_IDLE;
      an_n        <= 4'b1111;
      seg_n       <= SEG_BLANK;
      dp_n        <= 1'b1;
    end else begin
      if (digit_wrap) begin
        scan_cnt  <= '0;
        digit_idx <= digit_idx + 1'b1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end

      // Stage input -> p0: capture a whole frame's worth of time at the boundary
      if (frame_wrap) begin
        snap_min_p0 <= minutes;
        snap_sec_p0 <= seconds;
        snap_st_p0  <= next_st;
        // Entering pause restarts the blink visible so the frozen time shows at once
        if ((next_st != ST_PAUSED) || (snap_st_p0 != ST_PAUSED)) begin
          phase_on  <= 1'b1;
          frame_cnt <= '0;
        end else if (frame_cnt == FRAME_LAST) begin
          phase_on  <= !phase_on;
          frame_cnt <= '0;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end

      // Stage display -> pins: enables and segments move together
      an_n  <= an_sel;
      seg_n <= seg_sel;
      dp_n  <= dp_sel;
    end
  end

endmodule
